// File: rtl/control_sequencer.sv
// Hardwired Moore control unit: fetch (T0-T2) and per-opcode execute (T3-T7).
// Define CTRL_MEM_WAIT_EN to stall T1, ld T6 and st T7 until mem_ready is seen.
module control_sequencer #(
  parameter int ALU_OP_W = 4
) (
  input  logic                clock,
  input  logic                clear,
  input  logic                start,
  input  logic [31:0]         IR,
  input  logic                CON_FF,
  input  logic                mem_ready,
  output logic                Gra,
  output logic                Grb,
  output logic                Grc,
  output logic                Rin,
  output logic                Rout,
  output logic                BAout,
  output logic                Cout,
  output logic                PCout,
  output logic                PCin,
  output logic                IncPC,
  output logic                MARin,
  output logic                MDRin,
  output logic                MDRout,
  output logic                Read,
  output logic                Write,
  output logic                IRin,
  output logic                Yin,
  output logic                Zin,
  output logic                ZLowout,
  output logic                CONin,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                Run,
  output logic                illegal
);

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic [4:0] w_opcode;
  logic       w_is_rtype, w_is_itype, w_is_alu, w_is_ldi, w_is_ld, w_is_st;
  logic       w_is_br, w_is_nop, w_is_halt, w_is_addr;
  logic [1:0] w_alu_sel;
  logic       w_mem_go;

  assign w_opcode   = IR[31:27];
  assign w_is_rtype = (w_opcode >= 5'b00011) && (w_opcode <= 5'b00110);
  assign w_is_itype = (w_opcode >= 5'b01100) && (w_opcode <= 5'b01110);
  assign w_is_alu   = w_is_rtype || w_is_itype;
  assign w_is_ldi   = (w_opcode == 5'b00001);
  assign w_is_ld    = (w_opcode == 5'b00000);
  assign w_is_st    = (w_opcode == 5'b00010);
  assign w_is_br    = (w_opcode == 5'b10010);
  assign w_is_nop   = (w_opcode == 5'b11010);
  assign w_is_halt  = (w_opcode == 5'b11011);
  // ldi, ld and st all form an effective address from base register + constant
  assign w_is_addr  = w_is_ldi || w_is_ld || w_is_st;

`ifdef CTRL_MEM_WAIT_EN
  logic w_unused;
  assign w_mem_go = mem_ready;
  assign w_unused = ^IR[26:0];
`else
  logic w_unused;
  assign w_mem_go = 1'b1;
  assign w_unused = ^{IR[26:0], mem_ready};
`endif

  always_comb begin
    w_alu_sel = 2'd0;
    case (w_opcode)
      5'b00100:           w_alu_sel = 2'd1;
      5'b00101, 5'b01101: w_alu_sel = 2'd2;
      5'b00110, 5'b01110: w_alu_sel = 2'd3;
      default:            w_alu_sel = 2'd0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: w_next_state = start ? S_T0 : S_IDLE;
      S_T0:   w_next_state = S_T1;
      S_T1:   w_next_state = w_mem_go ? S_T2 : S_T1;
      S_T2:   w_next_state = S_T3;
      S_T3: begin
        if (w_is_halt)                          w_next_state = S_HALT;
        else if (w_is_alu || w_is_addr || w_is_br) w_next_state = S_T4;
        else                                    w_next_state = S_T0;
      end
      S_T4:   w_next_state = S_T5;
      S_T5:   w_next_state = (w_is_ld || w_is_st || w_is_br) ? S_T6 : S_T0;
      S_T6: begin
        if (w_is_ld)      w_next_state = w_mem_go ? S_T7 : S_T6;
        else if (w_is_st) w_next_state = S_T7;
        else              w_next_state = S_T0;
      end
      S_T7:   w_next_state = (w_is_st && !w_mem_go) ? S_T7 : S_T0;
      S_HALT: w_next_state = S_HALT;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; Rin = 1'b0; Rout = 1'b0; BAout = 1'b0;
    Cout = 1'b0; PCout = 1'b0; PCin = 1'b0; IncPC = 1'b0; MARin = 1'b0;
    MDRin = 1'b0; MDRout = 1'b0; Read = 1'b0; Write = 1'b0; IRin = 1'b0;
    Yin = 1'b0; Zin = 1'b0; ZLowout = 1'b0; CONin = 1'b0; illegal = 1'b0;
    alu_op = '0;
    Run = (r_state != S_IDLE) && (r_state != S_HALT);
    case (r_state)
      S_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; end
      S_T1: begin ZLowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
      S_T2: begin MDRout = 1'b1; IRin = 1'b1; end
      S_T3: begin
        if (w_is_alu) begin
          Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
        end else if (w_is_addr) begin
          Grb = 1'b1; BAout = 1'b1; Yin = 1'b1;
        end else if (w_is_br) begin
          Gra = 1'b1; Rout = 1'b1; CONin = 1'b1;
        end else if (!w_is_nop && !w_is_halt) begin
          illegal = 1'b1;
        end
      end
      S_T4: begin
        if (w_is_rtype) begin
          Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = ALU_OP_W'(w_alu_sel);
        end else if (w_is_itype) begin
          Cout = 1'b1; Zin = 1'b1; alu_op = ALU_OP_W'(w_alu_sel);
        end else if (w_is_addr) begin
          Cout = 1'b1; Zin = 1'b1;
        end else if (w_is_br) begin
          PCout = 1'b1; Yin = 1'b1;
        end
      end
      S_T5: begin
        if (w_is_alu || w_is_ldi) begin
          ZLowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
        end else if (w_is_ld || w_is_st) begin
          ZLowout = 1'b1; MARin = 1'b1;
        end else if (w_is_br) begin
          Cout = 1'b1; Zin = 1'b1;
        end
      end
      S_T6: begin
        if (w_is_ld) begin
          Read = 1'b1; MDRin = 1'b1;
        end else if (w_is_st) begin
          Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1;
        end else if (w_is_br && CON_FF) begin
          ZLowout = 1'b1; PCin = 1'b1;
        end
      end
      S_T7: begin
        if (w_is_ld) begin
          MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1;
        end else if (w_is_st) begin
          Write = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Only one source may drive the shared bus in any state
  always_ff @(posedge clock) begin
    if (!clear) begin
      assert ($countones({Rout, BAout, Cout, PCout, MDRout, ZLowout}) <= 1);
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Randomized bench for control_sequencer: per-instruction expected strobe sequences
// are built from the instruction's micro-step list and compared every cycle.
module tb_control_sequencer;
  localparam int ALU_OP_W = 4;

  logic clock = 1'b0;
  logic clear, start, CON_FF, mem_ready;
  logic [31:0] IR;
  logic Gra, Grb, Grc, Rin, Rout, BAout, Cout, PCout, PCin, IncPC, MARin;
  logic MDRin, MDRout, Read, Write, IRin, Yin, Zin, ZLowout, CONin, Run, illegal;
  logic [ALU_OP_W-1:0] alu_op;

  control_sequencer #(.ALU_OP_W(ALU_OP_W)) dut (
    .clock(clock), .clear(clear), .start(start), .IR(IR), .CON_FF(CON_FF),
    .mem_ready(mem_ready), .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin),
    .Rout(Rout), .BAout(BAout), .Cout(Cout), .PCout(PCout), .PCin(PCin),
    .IncPC(IncPC), .MARin(MARin), .MDRin(MDRin), .MDRout(MDRout), .Read(Read),
    .Write(Write), .IRin(IRin), .Yin(Yin), .Zin(Zin), .ZLowout(ZLowout),
    .CONin(CONin), .alu_op(alu_op), .Run(Run), .illegal(illegal)
  );

  always #5 clock = ~clock;

  // Bit positions of the observed output word
  localparam logic [31:0] GRA = 32'h1 << 21, GRB = 32'h1 << 20, GRC = 32'h1 << 19;
  localparam logic [31:0] RIN = 32'h1 << 18, ROUT = 32'h1 << 17, BAOUT = 32'h1 << 16;
  localparam logic [31:0] COUT = 32'h1 << 15, PCOUT = 32'h1 << 14, PCIN = 32'h1 << 13;
  localparam logic [31:0] INCPC = 32'h1 << 12, MARIN = 32'h1 << 11, MDRIN = 32'h1 << 10;
  localparam logic [31:0] MDROUT = 32'h1 << 9, READ = 32'h1 << 8, WRITE = 32'h1 << 7;
  localparam logic [31:0] IRIN = 32'h1 << 6, YIN = 32'h1 << 5, ZIN = 32'h1 << 4;
  localparam logic [31:0] ZLOW = 32'h1 << 3, CONIN = 32'h1 << 2, ILL = 32'h1 << 1;
  localparam logic [31:0] RUN = 32'h1;

  typedef struct {
    logic [31:0] w;
    bit          mem;
  } step_t;

  step_t exp_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  bit    in_idle = 1'b1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] obs();
    return {6'd0, alu_op, Gra, Grb, Grc, Rin, Rout, BAout, Cout, PCout, PCin,
            IncPC, MARin, MDRin, MDRout, Read, Write, IRin, Yin, Zin, ZLowout,
            CONin, illegal, Run};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_state(input string tag, input logic [31:0] exp);
    int n_drv;
    check_eq(tag, obs(), exp);
    n_drv = int'(Rout) + int'(BAout) + int'(Cout) + int'(PCout) + int'(MDRout) + int'(ZLowout);
    check_eq({tag, " bus"}, 32'(n_drv <= 1), 32'd1);
  endtask

  function automatic void push(input logic [31:0] w, input bit mem);
    step_t s;
    s.w   = w | RUN;
    s.mem = mem;
    exp_q.push_back(s);
  endfunction

  function automatic logic [31:0] alu(input int code);
    return 32'(code) << 22;
  endfunction

  // Expected micro-step list for one instruction, from fetch to its last execute step
  function automatic void build(input logic [4:0] op, input bit con);
    exp_q.delete();
    push(PCOUT | MARIN | INCPC | ZIN, 1'b0);
    push(ZLOW | PCIN | READ | MDRIN, 1'b1);
    push(MDROUT | IRIN, 1'b0);
    case (op)
      5'd3, 5'd4, 5'd5, 5'd6: begin
        push(GRB | ROUT | YIN, 1'b0);
        push(GRC | ROUT | ZIN | alu(int'(op) - 3), 1'b0);
        push(ZLOW | GRA | RIN, 1'b0);
      end
      5'd12, 5'd13, 5'd14: begin
        push(GRB | ROUT | YIN, 1'b0);
        push(COUT | ZIN | alu(op == 5'd12 ? 0 : (op == 5'd13 ? 2 : 3)), 1'b0);
        push(ZLOW | GRA | RIN, 1'b0);
      end
      5'd1: begin
        push(GRB | BAOUT | YIN, 1'b0);
        push(COUT | ZIN, 1'b0);
        push(ZLOW | GRA | RIN, 1'b0);
      end
      5'd0, 5'd2: begin
        push(GRB | BAOUT | YIN, 1'b0);
        push(COUT | ZIN, 1'b0);
        push(ZLOW | MARIN, 1'b0);
        if (op == 5'd0) begin
          push(READ | MDRIN, 1'b1);
          push(MDROUT | GRA | RIN, 1'b0);
        end else begin
          push(GRA | ROUT | MDRIN, 1'b0);
          push(WRITE, 1'b1);
        end
      end
      5'd18: begin
        push(GRA | ROUT | CONIN, 1'b0);
        push(PCOUT | YIN, 1'b0);
        push(COUT | ZIN, 1'b0);
        push(con ? (ZLOW | PCIN) : 32'd0, 1'b0);
      end
      5'd26, 5'd27: push(32'd0, 1'b0);
      default:      push(ILL, 1'b0);
    endcase
  endfunction

  task automatic ensure_running();
    if (in_idle) begin
      check_state("idle", 32'd0);
      start = 1'b1;
      tick();
      start = 1'b0;
      in_idle = 1'b0;
    end
  endtask

  // Entered with the DUT in T0; leaves it in T0 of the next instruction, or in IDLE
  task automatic run_instr(input logic [4:0] op, input bit con, input int abort_at,
                           input int nwait, input int halt_cycles);
    build(op, con);
    IR     = $urandom;
    CON_FF = 1'($urandom);
    for (int i = 0; i < exp_q.size(); i++) begin
      string tag;
      tag = $sformatf("op%02h T%0d", op, i);
      check_state(tag, exp_q[i].w);
      start = 1'($urandom);
      if (i == 2) IR = {op, 27'($urandom)};
      if (i == 3) CON_FF = con;
`ifdef CTRL_MEM_WAIT_EN
      if (exp_q[i].mem) begin
        int nw;
        nw = (nwait >= 0) ? nwait : $urandom_range(0, 3);
        for (int k = 0; k < nw; k++) begin
          mem_ready = 1'b0;
          tick();
          check_state({tag, " wait"}, exp_q[i].w);
        end
      end
      mem_ready = 1'b1;
`else
      mem_ready = 1'($urandom);
`endif
      if (i == abort_at) begin
        clear = 1'b1;
        mem_ready = 1'b0;
        tick();
        clear = 1'b0;
        start = 1'b0;
        check_state({tag, " clear"}, 32'd0);
        in_idle = 1'b1;
        return;
      end
      tick();
    end
    if (op == 5'd27) begin
      for (int k = 0; k < halt_cycles; k++) begin
        check_state("halt", 32'd0);
        start = 1'b1;
        mem_ready = 1'($urandom);
        tick();
      end
      clear = 1'b1;
      tick();
      clear = 1'b0;
      start = 1'b0;
      check_state("halt clear", 32'd0);
      in_idle = 1'b1;
    end
  endtask

  logic [4:0] legal_ops [13] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6,
                                 5'd12, 5'd13, 5'd14, 5'd18, 5'd26, 5'd27};

  initial begin
    clear = 1'b1; start = 1'b1; IR = 32'd0; CON_FF = 1'b0; mem_ready = 1'b0;
    tick();
    check_state("clear over start", 32'd0);
    clear = 1'b0; start = 1'b0;
    tick();
    check_state("idle hold", 32'd0);

    ensure_running();
    run_instr(5'd3, 1'b0, -1, -1, 0);        // add
    run_instr(5'd0, 1'b0, -1, 3, 0);         // ld with three wait cycles
    run_instr(5'd18, 1'b1, -1, -1, 0);       // br taken
    run_instr(5'd18, 1'b0, -1, -1, 0);       // br not taken
    run_instr(5'd31, 1'b0, -1, -1, 0);       // unknown opcode
    run_instr(5'd26, 1'b0, -1, -1, 0);       // nop
    run_instr(5'd2, 1'b0, 7, 2, 0);          // st, cleared in T7
    ensure_running();
    run_instr(5'd27, 1'b0, -1, -1, 20);      // halt

    for (int n = 0; n < 120; n++) begin
      logic [4:0] op;
      int abort_at;
      ensure_running();
      op = ($urandom_range(0, 3) == 0) ? 5'($urandom) : legal_ops[$urandom_range(0, 12)];
      abort_at = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 7) : -1;
      run_instr(op, 1'($urandom), abort_at, -1, $urandom_range(1, 4));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
